// File: rtl/rsa_word_bridge_pkg.sv
// Shared types and sizing for the word-serial RSA front-end.
// The key type, word geometry and bridge state encoding all live here.
package rsa_word_bridge_pkg;

  localparam int MOD_WIDTH     = 256;
  localparam int WORD_WIDTH    = 32;
  localparam int WORDS_PER_KEY = MOD_WIDTH / WORD_WIDTH;

  typedef logic [MOD_WIDTH-1:0] KeyType;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    SEND  = 2'd3
  } bridge_state_e;

endpackage

// File: rtl/rsa_word_serializer.sv
// Holds one KeyType result and streams it out least-significant word first,
// flagging the final word with last.
module rsa_word_serializer
  import rsa_word_bridge_pkg::*;
#(
  parameter int WORD_WIDTH = rsa_word_bridge_pkg::WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  KeyType                data,
  output logic                  valid,
  input  logic                  ready,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  last
);

  localparam int NWORDS = MOD_WIDTH / WORD_WIDTH;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  KeyType           result;
  logic [IDX_W-1:0] idx;
  logic             busy;

  assign valid = busy;
  assign word  = result[idx*WORD_WIDTH +: WORD_WIDTH];
  assign last  = busy && (idx == IDX_W'(NWORDS - 1));

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result <= '0;
      idx    <= '0;
      busy   <= 1'b0;
    end else if (load) begin
      result <= data;
      idx    <= '0;
      busy   <= 1'b1;
    end else if (busy && ready) begin
      if (last) begin
        busy <= 1'b0;
        idx  <= '0;
      end else begin
        idx  <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/rsa_word_bridge.sv
// Word-serial front-end for the RSA core: gathers msg/key/modulus from a word
// stream, issues one core request, then streams the result back out.
module rsa_word_bridge
  import rsa_word_bridge_pkg::*;
#(
  parameter int WORD_WIDTH = rsa_word_bridge_pkg::WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WORD_WIDTH-1:0] s_data,
  output logic                  core_valid,
  input  logic                  core_ready,
  output KeyType                core_msg,
  output KeyType                core_key,
  output KeyType                core_modulus,
  input  logic                  core_o_valid,
  output logic                  core_o_ready,
  input  KeyType                core_crypto,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WORD_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int NWORDS = MOD_WIDTH / WORD_WIDTH;
  localparam int NSLOTS = 3 * NWORDS;
  localparam int CNT_W  = $clog2(NSLOTS);

  bridge_state_e   state;
  logic [CNT_W-1:0] cnt;
  logic [WORD_WIDTH-1:0] op_buf [NSLOTS];

  logic accept;
  logic last_slot;
  logic capture;

  assign s_ready      = (state == LOAD);
  assign core_valid   = (state == ISSUE);
  assign core_o_ready = (state == WAIT);

  assign accept    = s_valid && s_ready;
  assign last_slot = (cnt == CNT_W'(NSLOTS - 1));
  assign capture   = core_o_valid && core_o_ready;

  // NOTE: the operand buffer is pure storage whose contents are only consumed
  // after a full load, so it carries no reset and can map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (accept) op_buf[cnt] <= s_data;
  end

  // Operands are copied out on the final word so the core sees a stable request
  // while the buffer is being refilled for the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_msg     <= '0;
      core_key     <= '0;
      core_modulus <= '0;
    end else if (accept && last_slot) begin
      for (int i = 0; i < NWORDS; i++) begin
        core_msg[i*WORD_WIDTH +: WORD_WIDTH] <= op_buf[i];
        core_key[i*WORD_WIDTH +: WORD_WIDTH] <= op_buf[NWORDS + i];
        core_modulus[i*WORD_WIDTH +: WORD_WIDTH] <=
          (i == NWORDS - 1) ? s_data : op_buf[2*NWORDS + i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LOAD;
      cnt   <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            if (last_slot) begin
              state <= ISSUE;
              cnt   <= '0;
            end else begin
              cnt   <= cnt + CNT_W'(1);
            end
          end
        end
        ISSUE: if (core_ready)                   state <= WAIT;
        WAIT:  if (core_o_valid)                 state <= SEND;
        SEND:  if (m_valid && m_ready && m_last) state <= LOAD;
        default:                                 state <= LOAD;
      endcase
    end
  end

  rsa_word_serializer #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_serializer (
    .clk  (clk),
    .rst  (rst),
    .load (capture),
    .data (core_crypto),
    .valid(m_valid),
    .ready(m_ready),
    .word (m_data),
    .last (m_last)
  );

endmodule

// File: tb/tb_rsa_word_bridge.sv
// Directed bench for rsa_word_bridge with a hand-driven RSA core stub.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_rsa_word_bridge;
  import rsa_word_bridge_pkg::*;

  localparam int W = 32;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         core_valid;
  logic         core_ready;
  KeyType       core_msg, core_key, core_modulus;
  logic         core_o_valid;
  logic         core_o_ready;
  KeyType       core_crypto;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic         m_last;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;
  int n_req = 0;

  rsa_word_bridge #(.WORD_WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .core_valid  (core_valid),
    .core_ready  (core_ready),
    .core_msg    (core_msg),
    .core_key    (core_key),
    .core_modulus(core_modulus),
    .core_o_valid(core_o_valid),
    .core_o_ready(core_o_ready),
    .core_crypto (core_crypto),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (s_valid && s_ready)       n_acc <= n_acc + 1;
    if (core_valid && core_ready) n_req <= n_req + 1;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one word at a falling edge and hold it until accepted.
  task automatic push(input logic [W-1:0] w);
    int b;
    s_valid = 1'b1;
    s_data  = w;
    b = 0;
    while (!s_ready && b < 50) begin
      @(posedge clk);
      @(negedge clk);
      b++;
    end
    if (!s_ready) check("push_timeout", 256'(s_ready), 256'(1));
    @(posedge clk);
    @(negedge clk);
  endtask

  KeyType       exp_msg, exp_key, exp_mod, res1;
  logic [31:0]  pat;
  logic [W-1:0] prev_d;
  logic         prev_l, prev_stall;
  int           got_n, k, acc_base;

  initial begin
    rst = 1'b0; s_valid = 1'b0; s_data = '0; core_ready = 1'b0;
    core_o_valid = 1'b0; core_crypto = '0; m_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      exp_msg[i*W +: W] = 32'(i + 1);
      exp_key[i*W +: W] = 32'(i + 9);
      exp_mod[i*W +: W] = 32'(i + 17);
      res1[i*W +: W]    = 32'hC0DE_0000 + 32'(i);
    end

    // Reset state, both while held and after release.
    repeat (3) @(negedge clk);
    check("rst_s_ready",      256'(s_ready), 256'(1));
    check("rst_core_valid",   256'(core_valid), 256'(0));
    check("rst_core_o_ready", 256'(core_o_ready), 256'(0));
    check("rst_m_valid",      256'(m_valid), 256'(0));
    check("rst_m_last",       256'(m_last), 256'(0));
    check("rst_m_data",       256'(m_data), 256'(0));
    check("rst_operands",     core_msg | core_key | core_modulus, 256'(0));
    rst = 1'b1;
    @(negedge clk);
    check("rel_s_ready",    256'(s_ready), 256'(1));
    check("rel_core_valid", 256'(core_valid), 256'(0));

    // Partial load of 10 words, then an asynchronous reset mid-cycle.
    for (int i = 0; i < 10; i++) push(32'hBAD0_0000 + 32'(i));
    s_valid = 1'b0;
    #2 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_s_ready", 256'(s_ready), 256'(1));

    // Full load 1..24 back-to-back.
    for (int i = 0; i < 3*N; i++) begin
      push(32'(i + 1));
      if (i == 3*N - 2) check("cv_before_last", 256'(core_valid), 256'(0));
    end
    s_valid = 1'b0;
    check("cv_after_last", 256'(core_valid), 256'(1));
    check("s_ready_issue", 256'(s_ready), 256'(0));
    check("core_msg",      core_msg, exp_msg);
    check("core_key",      core_key, exp_key);
    check("core_modulus",  core_modulus, exp_mod);
    acc_base = n_acc;

    // Core stalls 5 cycles; stray result valid and input words must be ignored.
    s_valid = 1'b1; s_data = 32'd5;
    core_o_valid = 1'b1; core_crypto = {8{32'hDEAD_BEEF}};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_core_valid", 256'(core_valid), 256'(1));
      check("stall_msg",        core_msg, exp_msg);
      check("stall_mod",        core_modulus, exp_mod);
      check("stall_o_ready",    256'(core_o_ready), 256'(0));
    end
    core_o_valid = 1'b0;
    core_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    core_ready = 1'b0;
    check("wait_o_ready",   256'(core_o_ready), 256'(1));
    check("wait_core_valid", 256'(core_valid), 256'(0));
    check("req_once",       256'(n_req), 256'(1));
    repeat (2) @(negedge clk);
    check("wait_no_m_valid", 256'(m_valid), 256'(0));

    // Capture result; first word is visible the next cycle.
    core_o_valid = 1'b1; core_crypto = res1;
    @(posedge clk);
    @(negedge clk);
    core_o_valid = 1'b0;
    check("send_m_valid", 256'(m_valid), 256'(1));
    check("send_word0",   256'(m_data), 256'(res1[W-1:0]));
    check("send_o_ready", 256'(core_o_ready), 256'(0));

    // SEND with an irregular m_ready pattern.
    pat = 32'hB3A5_6C9D;
    got_n = 0; k = 0; prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
    while (got_n < N && k < 64) begin
      if (prev_stall) begin
        check("hold_data", 256'(m_data), 256'(prev_d));
        check("hold_last", 256'(m_last), 256'(prev_l));
      end
      m_ready = pat[k % 32];
      if (m_valid && m_ready) begin
        check($sformatf("word%0d", got_n), 256'(m_data), 256'(res1[got_n*W +: W]));
        check($sformatf("last%0d", got_n), 256'(m_last), 256'(got_n == N - 1));
        got_n++;
      end
      prev_stall = m_valid && !m_ready;
      prev_d = m_data;
      prev_l = m_last;
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    m_ready = 1'b0;
    check("send_count",     256'(got_n), 256'(N));
    check("no_accept_busy", 256'(n_acc), 256'(acc_base));
    check("s_ready_rise",   256'(s_ready), 256'(1));
    @(posedge clk);
    @(negedge clk);
    check("accept_after",   256'(n_acc), 256'(acc_base + 1));

    // Second request: msg=5 (already accepted), key=3, modulus=33.
    for (int i = 1; i < 3*N; i++) begin
      push((i == N) ? 32'd3 : (i == 2*N) ? 32'd33 : 32'd0);
      if (i == 15) check("ops_stable_load", core_msg, exp_msg);
    end
    s_valid = 1'b0;
    check("msg5",  core_msg, 256'd5);
    check("key3",  core_key, 256'd3);
    check("mod33", core_modulus, 256'd33);
    core_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    core_ready = 1'b0;
    check("req_twice", 256'(n_req), 256'(2));
    core_o_valid = 1'b1; core_crypto = 256'h1A; m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    core_o_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      check($sformatf("rsa_valid%0d", i), 256'(m_valid), 256'(1));
      check($sformatf("rsa_word%0d", i),  256'(m_data), (i == 0) ? 256'h1A : 256'h0);
      check($sformatf("rsa_last%0d", i),  256'(m_last), 256'(i == N - 1));
      @(posedge clk);
      @(negedge clk);
    end
    m_ready = 1'b0;
    check("end_m_valid", 256'(m_valid), 256'(0));
    check("end_s_ready", 256'(s_ready), 256'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
